// File: rtl/axim_pkg.sv
// Shared definitions for the AXI write engine.
//   state_t        : top-level run state (IDLE / RUN / DONE)
//   AXI_RESP_OKAY  : the only B response treated as success
//   awlen_of()     : AXI awlen value for a given burst length in beats
package axim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'd0;

  function automatic logic [7:0] awlen_of(input int burst_len);
    return 8'(burst_len - 1);
  endfunction

endpackage

// File: rtl/axim_w_beat_gen.sv
// W-channel beat generator: walks the beats of each burst, raises wlast on
// the final beat and advances an incrementing data pattern that runs on
// continuously across bursts.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load, seed   : on load, the data pattern restarts at seed
//   grant        : a new burst may begin (its AW has already been accepted)
//   burst_start  : a new burst begins at this clock edge (combinational)
//   wready       : AXI W ready
//   wvalid, wdata, wlast : registered AXI W outputs
module axim_w_beat_gen #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  logic              grant,
  output logic              burst_start,
  input  logic              wready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [BEAT_W-1:0] beat_reg;
  logic              beat_acc;
  logic              slot_free;

  assign beat_acc = wvalid & wready;
  // The W slot frees up either when idle or as the final beat is taken, so
  // a granted follow-on burst streams with no bubble.
  assign slot_free   = !wvalid | (beat_acc & wlast);
  assign burst_start = slot_free & grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      wvalid   <= 1'b0;
      wlast    <= 1'b0;
      wdata    <= '0;
      beat_reg <= '0;
    end else if (load) begin
      wvalid   <= 1'b0;
      wlast    <= 1'b0;
      wdata    <= seed;
      beat_reg <= '0;
    end else begin
      if (beat_acc) begin
        wdata <= wdata + 1'b1;
      end
      if (slot_free) begin
        wvalid   <= grant;
        wlast    <= grant && (BURST_LEN == 1);
        beat_reg <= '0;
      end else if (beat_acc) begin
        beat_reg <= beat_reg + 1'b1;
        wlast    <= (32'(beat_reg) + 32'd1 == 32'(BURST_LEN - 1));
      end
    end
  end

endmodule

// File: rtl/axim_write_engine.sv
// AXI write master: on start, issues cfg_num_bursts fixed-length bursts from
// cfg_base_addr with an incrementing data pattern beginning at cfg_seed.
// Up to MAX_OUT bursts may have AW accepted without their B response.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, cfg_*               : run request and its configuration
//   busy, done, err, err_cnt   : run status, error flag and error count
//   axi_aw*, axi_w*, axi_b*    : AXI write address / data / response channels
module axim_write_engine
  import axim_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 25,
  parameter int BURST_LEN = 32,
  parameter int MAX_OUT   = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_bursts,
  input  logic [DATA_W-1:0] cfg_seed,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              axi_awready,
  output logic              axi_awvalid,
  output logic [7:0]        axi_awlen,
  output logic [ADDR_W-1:0] axi_awaddr,
  input  logic              axi_wready,
  output logic              axi_wvalid,
  output logic [DATA_W-1:0] axi_wdata,
  output logic              axi_wlast,
  output logic              axi_bready,
  input  logic              axi_bvalid,
  input  logic [1:0]        axi_bresp
);

  state_t           state;
  logic [CNT_W-1:0] num_bursts_reg;
  logic [CNT_W-1:0] aw_issued_reg;
  logic [CNT_W-1:0] b_rcvd_reg;
  logic [CNT_W-1:0] w_started_reg;
  logic [CNT_W-1:0] aw_issued_next;
  logic [CNT_W-1:0] b_rcvd_next;
  logic             accept_start;
  logic             aw_acc;
  logic             b_acc;
  logic             aw_more;
  logic             grant;
  logic             burst_start;

  assign axi_awlen  = awlen_of(BURST_LEN);
  assign axi_bready = 1'b1;

  assign accept_start   = start & (state == ST_IDLE);
  assign aw_acc         = axi_awvalid & axi_awready;
  assign b_acc          = axi_bvalid & (state == ST_RUN);
  assign aw_issued_next = aw_issued_reg + CNT_W'(aw_acc);
  assign b_rcvd_next    = b_rcvd_reg + CNT_W'(b_acc);

  // Look-ahead on the post-edge counts keeps awvalid registered yet lets it
  // re-assert right after an accept or a freeing B response.
  assign aw_more = (aw_issued_next < num_bursts_reg) &&
                   ((aw_issued_next - b_rcvd_next) < CNT_W'(MAX_OUT));

  // Registered AW count keeps each W burst strictly behind its AW.
  assign grant = (state == ST_RUN) && (w_started_reg < aw_issued_reg);

  axim_w_beat_gen #(
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN)
  ) u_w_beat_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept_start),
    .seed       (cfg_seed),
    .grant      (grant),
    .burst_start(burst_start),
    .wready     (axi_wready),
    .wvalid     (axi_wvalid),
    .wdata      (axi_wdata),
    .wlast      (axi_wlast)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_cnt        <= '0;
      axi_awvalid    <= 1'b0;
      axi_awaddr     <= '0;
      num_bursts_reg <= '0;
      aw_issued_reg  <= '0;
      b_rcvd_reg     <= '0;
      w_started_reg  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_start) begin
            busy           <= 1'b1;
            err            <= 1'b0;
            err_cnt        <= '0;
            num_bursts_reg <= cfg_num_bursts;
            aw_issued_reg  <= '0;
            b_rcvd_reg     <= '0;
            w_started_reg  <= '0;
            axi_awaddr     <= cfg_base_addr;
            axi_awvalid    <= (cfg_num_bursts != '0);
            state          <= (cfg_num_bursts != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          aw_issued_reg <= aw_issued_next;
          b_rcvd_reg    <= b_rcvd_next;
          axi_awvalid   <= aw_more;
          if (burst_start) begin
            w_started_reg <= w_started_reg + 1'b1;
          end
          if (aw_acc) begin
            axi_awaddr <= axi_awaddr + ADDR_W'(BURST_LEN);
          end
          if (b_acc && (axi_bresp != AXI_RESP_OKAY)) begin
            err <= 1'b1;
            if (err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
          if (b_rcvd_next == num_bursts_reg) begin
            axi_awvalid <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axim_write_engine.sv
// Randomised self-checking bench for axim_write_engine. A slave model drives
// random ready/B timing; every handshake is compared against the expected
// address / data / wlast derived directly from the run configuration.
module tb_axim_write_engine;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 25;
  localparam int BURST_LEN = 32;
  localparam int MAX_OUT   = 2;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [CNT_W-1:0]  cfg_num_bursts = '0;
  logic [DATA_W-1:0] cfg_seed = '0;
  logic              busy, done, err;
  logic [CNT_W-1:0]  err_cnt;
  logic              axi_awready = 1'b0;
  logic              axi_awvalid;
  logic [7:0]        axi_awlen;
  logic [ADDR_W-1:0] axi_awaddr;
  logic              axi_wready = 1'b0;
  logic              axi_wvalid;
  logic [DATA_W-1:0] axi_wdata;
  logic              axi_wlast;
  logic              axi_bready;
  logic              axi_bvalid = 1'b0;
  logic [1:0]        axi_bresp = 2'd0;

  always #5 clk = ~clk;

  axim_write_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .axi_awready(axi_awready), .axi_awvalid(axi_awvalid), .axi_awlen(axi_awlen),
    .axi_awaddr(axi_awaddr), .axi_wready(axi_wready), .axi_wvalid(axi_wvalid),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_bready(axi_bready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state for the current run.
  logic [ADDR_W-1:0] m_base;
  logic [DATA_W-1:0] m_seed;
  int m_n = 0, m_err_idx = -1, m_stall = 0;
  int aw_cnt = 0, beat_cnt = 0, b_cnt = 0, pending_b = 0, b_credit = 0, b_prev = 0;
  bit b_limit = 1'b0, mon_en = 1'b0;
  bit aw_stalled = 1'b0, w_stalled = 1'b0;
  logic [ADDR_W-1:0] aw_saved;
  logic [DATA_W-1:0] wd_saved;
  logic              wl_saved;

  // Slave model + monitor: at each falling edge, choose this cycle's
  // ready/B values, then score the handshakes that the next rising edge makes.
  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      axi_bvalid  = 1'b0;
      axi_bresp   = 2'd0;
      aw_stalled  = 1'b0;
      w_stalled   = 1'b0;
    end else begin
      b_prev = b_cnt;
      if (aw_stalled) begin
        chk("aw_hold_valid", 32'(axi_awvalid), 32'd1);
        chk("aw_hold_addr", 32'(axi_awaddr), 32'(aw_saved));
      end
      if (w_stalled) begin
        chk("w_hold_valid", 32'(axi_wvalid), 32'd1);
        chk("w_hold_data", 32'(axi_wdata), 32'(wd_saved));
        chk("w_hold_last", 32'(axi_wlast), 32'(wl_saved));
      end
      if (pending_b > 0 && (!b_limit || b_credit > 0) && $urandom_range(99) >= m_stall) begin
        axi_bvalid = 1'b1;
        axi_bresp  = (b_cnt == m_err_idx) ? 2'd2 : 2'd0;
        b_cnt++;
        pending_b--;
        if (b_limit) b_credit--;
      end else begin
        axi_bvalid = 1'b0;
        axi_bresp  = 2'd0;
      end
      axi_awready = ($urandom_range(99) >= m_stall);
      axi_wready  = ($urandom_range(99) >= m_stall);
      if (axi_wvalid && axi_wready) begin
        chk("w_count", 32'(beat_cnt < m_n * BURST_LEN), 32'd1);
        chk("w_after_aw", 32'(beat_cnt / BURST_LEN < aw_cnt), 32'd1);
        chk("wdata", 32'(axi_wdata), 32'(DATA_W'(m_seed + DATA_W'(beat_cnt))));
        chk("wlast", 32'(axi_wlast), 32'((beat_cnt % BURST_LEN) == BURST_LEN - 1));
        if ((beat_cnt % BURST_LEN) == BURST_LEN - 1) pending_b++;
        beat_cnt++;
      end
      if (axi_awvalid && axi_awready) begin
        chk("aw_count", 32'(aw_cnt < m_n), 32'd1);
        chk("aw_outstanding", 32'((aw_cnt - b_prev) < MAX_OUT), 32'd1);
        chk("awaddr", 32'(axi_awaddr), 32'(ADDR_W'(m_base + ADDR_W'(aw_cnt * BURST_LEN))));
        chk("awlen", 32'(axi_awlen), 32'(BURST_LEN - 1));
        aw_cnt++;
      end
      aw_stalled = axi_awvalid && !axi_awready;
      aw_saved   = axi_awaddr;
      w_stalled  = axi_wvalid && !axi_wready;
      wd_saved   = axi_wdata;
      wl_saved   = axi_wlast;
    end
  end

  task automatic run_start(input logic [ADDR_W-1:0] base, input int n,
                           input logic [DATA_W-1:0] seed, input int eidx, input int stall);
    @(posedge clk);
    m_base = base; m_n = n; m_seed = seed; m_err_idx = eidx; m_stall = stall;
    aw_cnt = 0; beat_cnt = 0; b_cnt = 0; pending_b = 0; b_limit = 1'b0; b_credit = 0;
    @(negedge clk);
    cfg_base_addr  = base;
    cfg_num_bursts = CNT_W'(n);
    cfg_seed       = seed;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("awvalid_after_start", 32'(axi_awvalid), 32'(n != 0));
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_cnt_cleared", 32'(err_cnt), 32'd0);
  endtask

  task automatic run_finish(input string name);
    int  cyc;
    bit  seen;
    int  exp_e;
    seen = 1'b0;
    for (cyc = 0; cyc < 8000; cyc++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    exp_e = (m_err_idx >= 0 && m_err_idx < m_n) ? 1 : 0;
    chk("done_seen", 32'(seen), 32'd1);
    if (m_n == 0) chk("zero_done_latency", 32'(cyc), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err_at_done", 32'(err), 32'(exp_e));
    chk("err_cnt_at_done", 32'(err_cnt), 32'(exp_e));
    chk("aw_total", 32'(aw_cnt), 32'(m_n));
    chk("beat_total", 32'(beat_cnt), 32'(m_n * BURST_LEN));
    chk("b_total", 32'(b_cnt), 32'(m_n));
    @(negedge clk);
    chk("done_pulse_once", 32'(done), 32'd0);
    $display("run %s: n=%0d aw=%0d beats=%0d b=%0d err=%0b err_cnt=%0d cycles=%0d",
             name, m_n, aw_cnt, beat_cnt, b_cnt, err, err_cnt, cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_awvalid", 32'(axi_awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi_wvalid), 32'd0);
    chk("rst_wlast", 32'(axi_wlast), 32'd0);
    chk("rst_awaddr", 32'(axi_awaddr), 32'd0);
    chk("rst_wdata", 32'(axi_wdata), 32'd0);
    chk("bready", 32'(axi_bready), 32'd1);
    mon_en = 1'b1;

    run_start(25'h0, 1, 16'd100, -1, 0);
    run_finish("single");

    run_start(25'h1FFFFF0, 3, 16'hFFF0, -1, 0);
    run_finish("wrap");

    // B responses held off: only MAX_OUT AWs may go out.
    run_start(25'h400, 5, 16'h1234, -1, 0);
    @(posedge clk);
    b_limit = 1'b1;
    b_credit = 0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("hold_aw_count", 32'(aw_cnt), 32'(MAX_OUT));
    chk("hold_awvalid", 32'(axi_awvalid), 32'd0);
    @(posedge clk);
    b_credit = 1;
    for (int i = 0; i < 50 && b_cnt == 0; i++) @(posedge clk);
    @(negedge clk);
    chk("release_awvalid", 32'(axi_awvalid), 32'd1);
    b_limit = 1'b0;
    run_finish("maxout");

    for (int k = 0; k < 4; k++) begin
      run_start(ADDR_W'($urandom), $urandom_range(6, 1), DATA_W'($urandom),
                (k == 2) ? 0 : -1, 35);
      run_finish("stall");
    end

    run_start(25'h100, 4, 16'h5555, 1, 0);
    run_finish("bresp_err");
    run_start(25'h200, 2, 16'h0, -1, 0);
    run_finish("err_clear");

    run_start(25'h300, 0, 16'd7, -1, 0);
    chk("zero_no_wvalid", 32'(axi_wvalid), 32'd0);
    run_finish("zero");

    // start while busy must not disturb the run in progress.
    run_start(25'h1000, 3, 16'h4000, -1, 20);
    repeat (10) @(negedge clk);
    cfg_base_addr  = 25'h1ABCDE;
    cfg_num_bursts = 16'd9;
    cfg_seed       = 16'hDEAD;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    run_finish("busy_start");

    // Reset mid-burst aborts at once.
    run_start(25'h2000, 4, 16'h10, -1, 0);
    repeat (20) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_awvalid", 32'(axi_awvalid), 32'd0);
    chk("abort_wvalid", 32'(axi_wvalid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    mon_en = 1'b1;

    run_start(25'h40, 2, 16'h77, -1, 10);
    run_finish("after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axim_write_engine.md
Name: axim_write_engine

Overview:
- Parametrised AXI write master for the SDRAM memory interface; next generation of the single-burst write controller.
- On a start pulse, issues a programmable number of fixed-length bursts from a programmable base word address, with an incrementing data pattern.
- Supports multiple outstanding bursts and reports response errors.
- Sits between the test/control logic and the AXI slave port of the SDRAM controller.

Parameters:
- DATA_W, 16, AXI write data width in bits.
- ADDR_W, 25, word-address width.
- BURST_LEN, 32, beats per burst, 1..256; awlen = BURST_LEN-1.
- MAX_OUT, 4, maximum bursts with AW accepted but B not yet received, 1..15.
- CNT_W, 16, width of the burst-count and error-count fields.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  single-cycle start pulse, clk domain.
- cfg_base_addr  in  ADDR_W  first burst word address; sampled on accepted start.
- cfg_num_bursts  in  CNT_W  number of bursts; sampled on accepted start.
- cfg_seed  in  DATA_W  first data word; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until the done cycle.
- done  out  1  one-cycle pulse when the last B is received.
- err  out  1  sticky; set if any bresp != 0 in the current run.
- err_cnt  out  CNT_W  count of non-OKAY responses, saturating.
- axi_awready  in  1  AW ready.
- axi_awvalid  out  1  AW valid.
- axi_awlen  out  8  constant BURST_LEN-1.
- axi_awaddr  out  ADDR_W  burst word address.
- axi_wready  in  1  W ready.
- axi_wvalid  out  1  W valid.
- axi_wdata  out  DATA_W  write data.
- axi_wlast  out  1  last beat of burst.
- axi_bready  out  1  always 1.
- axi_bvalid  in  1  B valid.
- axi_bresp  in  2  B response.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Reset values: busy=0, done=0, err=0, err_cnt=0, awvalid=0, wvalid=0, wlast=0, awaddr=0, wdata=0. Reset mid-run aborts immediately; valids are low on the next cycle with no further handshakes.
- All outputs are registered, except axi_awlen and axi_bready, which are constants.
- States: IDLE, RUN, DONE.
- IDLE: start with num_bursts>0 latches cfg, clears err and err_cnt, then goes to RUN. start with num_bursts=0 goes to DONE with no AXI traffic.
- start is ignored while busy=1.
- RUN, AW channel:
  - awvalid asserts when aw_issued < num_bursts and (aw_issued - b_rcvd) < MAX_OUT.
  - First awaddr = base. Each accept (awvalid & awready) increments aw_issued and adds BURST_LEN to awaddr, modulo 2^ADDR_W (wrap permitted).
  - awvalid/awaddr hold stable until accepted.
  - After an accept, awvalid may re-assert on the next cycle (back-to-back bursts).
- RUN, W channel:
  - A burst may start only when w_bursts < aw_issued, i.e. W never leads its AW.
  - wvalid holds until wready. Each accepted beat advances wdata by 1, modulo 2^DATA_W; the pattern is continuous across bursts and starts at seed.
  - wlast is high on beat BURST_LEN-1 of each burst, and on every beat when BURST_LEN=1.
  - Zero-bubble streaming within and across bursts when wready stays high and AW is ahead.
- RUN, B channel:
  - Each bvalid increments b_rcvd.
  - bresp != 0 sets err and increments err_cnt, saturating at all-ones. An error does not abort the run.
  - When b_rcvd reaches num_bursts, go to DONE.
- Simultaneous AW accept and B in one cycle: the outstanding count is unchanged.
- DONE: done=1 for one cycle, busy=0, return to IDLE. err and err_cnt hold until the next accepted start.
- Latency: awvalid rises 1 cycle after start, wvalid rises no earlier than 1 cycle after the first AW accept.

Decomposition:
- Shared package axim_pkg:
  - state encodings
  - AXI_RESP_OKAY = 2'd0
  - helper constant for awlen
- One natural sub-module, axim_w_beat_gen: burst beat counter, wlast generation and data-pattern increment.
- The AW issue logic, outstanding tracking and top FSM remain in axim_write_engine.

Test Plan:
- BURST_LEN=32, num_bursts=1, base=0, seed=100, ready always 1:
  - One AW at 0, awlen=31.
  - Data 100..131, wlast on 131.
  - done pulse, err=0.
- num_bursts=3, base=0x1FFFFF0 (ADDR_W=25), seed=0xFFF0:
  - awaddr = 0x1FFFFF0, 0x0000010, 0x0000030 (wraps).
  - wdata wraps 0xFFFF→0x0000 at beat 16.
  - 96 beats total.
- MAX_OUT=2, num_bursts=5, B held off:
  - Exactly 2 AW accepted, then awvalid=0.
  - Releasing one B allows the third AW on the following cycle.
- Random awready/wready stalls:
  - awaddr, wdata and wlast stable while valid and not ready.
  - Beat ordering intact.
  - W never starts before its AW.
- bresp=2 on the 2nd of 4 bursts:
  - Run completes, done pulses, err=1, err_cnt=1.
  - Next start clears both.
- Corner cases:
  - num_bursts=0 → done 2 cycles after start, no valids.
  - start while busy → ignored.
  - reset mid-burst → all valids 0 next cycle, busy=0.
